// File: rtl/vram_slot_arbiter.sv
// VRAM time-slot scheduler for the tilemap generator.
// Each tile period is 8 slots of PHASES clocks: even slots fetch render data
// (scroll, map A, fix, map B) while rendering, odd slots (and every slot when
// rendering is off) can be granted to the CPU through a req/ack handshake.
module vram_slot_arbiter #(
    parameter int ADDR_W = 14,
    parameter int PHASES = 4
) (
    input  logic              clk_24M,
    input  logic              RES,
    input  logic              line_start,
    input  logic              render_en,
    input  logic [ADDR_W-1:0] scroll_addr,
    input  logic [ADDR_W-1:0] mapa_addr,
    input  logic [ADDR_W-1:0] fix_addr,
    input  logic [ADDR_W-1:0] mapb_addr,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [1:0]        cpu_be,
    input  logic [7:0]        cpu_din,
    output logic              cpu_ack,
    output logic [15:0]       cpu_rdata,
    output logic [15:0]       rd_data,
    output logic [3:0]        rd_stb,
    output logic [ADDR_W-2:0] RA,
    output logic [1:0]        RCS,
    output logic              ROE,
    output logic [1:0]        RWE,
    output logic [15:0]       VD_OUT,
    input  logic [15:0]       VD_IN,
    output logic [2:0]        slot
);

    localparam int PH_W  = $clog2(PHASES);
    localparam int CYC_W = 3 + PH_W;

    typedef enum logic [1:0] {
        ACC_IDLE,
        ACC_RENDER,
        ACC_CPU_RD,
        ACC_CPU_WR
    } acc_t;

    acc_t              acc_q, acc_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        be_q, be_d;
    logic [PH_W-1:0]   phase_d;
    logic [2:0]        slot_d;
    logic [ADDR_W-1:0] render_addr;

    logic [ADDR_W-2:0] ra_d;
    logic [1:0]        rcs_d, rwe_d;
    logic              roe_d, ack_d;
    logic [3:0]        stb_d;
    logic [15:0]       vd_out_d, rd_data_d, cpu_rdata_d;

    assign phase_d = cyc_d[PH_W-1:0];
    assign slot_d  = cyc_d[CYC_W-1:PH_W];
    assign slot    = cyc_q[CYC_W-1:PH_W];

    // Pick the render fetch address belonging to the slot about to start.
    always_comb begin
        render_addr = scroll_addr;
        unique case (slot_d[2:1])
            2'd0: render_addr = scroll_addr;
            2'd1: render_addr = mapa_addr;
            2'd2: render_addr = fix_addr;
            2'd3: render_addr = mapb_addr;
        endcase
    end

    // Slot counter and access latch; reset still lets the slot-0 scroll fetch
    // run so rendering resumes without losing a tile's scroll value.
    always_ff @(posedge clk_24M) begin
        if (RES) begin
            cyc_q  <= '0;
            acc_q  <= render_en ? ACC_RENDER : ACC_IDLE;
            addr_q <= scroll_addr;
            be_q   <= '0;
        end else begin
            cyc_q  <= cyc_d;
            acc_q  <= acc_d;
            addr_q <= addr_d;
            be_q   <= be_d;
        end
    end

    // Advance the counter and decide the owner of a slot as it reaches phase 0;
    // a line_start lands on phase 0 too, which drops whatever was in flight.
    always_comb begin
        cyc_d  = line_start ? '0 : cyc_q + CYC_W'(1);
        acc_d  = acc_q;
        addr_d = addr_q;
        be_d   = be_q;
        if (phase_d == '0) begin
            if (render_en && !slot_d[0]) begin
                acc_d  = ACC_RENDER;
                addr_d = render_addr;
                be_d   = '0;
            end else if (cpu_req && !cpu_ack) begin
                acc_d  = cpu_we ? ACC_CPU_WR : ACC_CPU_RD;
                addr_d = cpu_addr;
                be_d   = cpu_be;
            end else begin
                acc_d  = ACC_IDLE;
            end
        end
    end

    // Compute next-cycle bus pins, strobes and return data from the access
    // and phase that the coming clock will enter.
    always_comb begin
        ra_d        = RA;
        rcs_d       = 2'b11;
        roe_d       = 1'b1;
        rwe_d       = 2'b11;
        vd_out_d    = VD_OUT;
        ack_d       = 1'b0;
        stb_d       = '0;
        rd_data_d   = rd_data;
        cpu_rdata_d = cpu_rdata;
        if (acc_d != ACC_IDLE) begin
            ra_d                    = addr_d[ADDR_W-2:0];
            rcs_d[addr_d[ADDR_W-1]] = 1'b0;
        end
        if (phase_d == PH_W'(1) || phase_d == PH_W'(2)) begin
            if (acc_d == ACC_RENDER || acc_d == ACC_CPU_RD) begin
                roe_d = 1'b0;
            end
            if (acc_d == ACC_CPU_WR) begin
                rwe_d = ~be_d;
            end
        end
        if (phase_d == '0 && acc_d == ACC_CPU_WR) begin
            vd_out_d = {cpu_din, cpu_din};
        end
        if (phase_d == PH_W'(PHASES-1)) begin
            if (acc_d == ACC_RENDER) begin
                stb_d[slot_d[2:1]] = 1'b1;
                rd_data_d          = VD_IN;
            end else if (acc_d == ACC_CPU_RD) begin
                ack_d       = 1'b1;
                cpu_rdata_d = VD_IN;
            end else if (acc_d == ACC_CPU_WR) begin
                ack_d = 1'b1;
            end
        end
    end

    // Register every external pin so the VRAM sees glitch-free strobes.
    always_ff @(posedge clk_24M) begin
        if (RES) begin
            RA        <= '0;
            RCS       <= 2'b11;
            ROE       <= 1'b1;
            RWE       <= 2'b11;
            VD_OUT    <= '0;
            cpu_ack   <= 1'b0;
            rd_stb    <= '0;
            rd_data   <= '0;
            cpu_rdata <= '0;
        end else begin
            RA        <= ra_d;
            RCS       <= rcs_d;
            ROE       <= roe_d;
            RWE       <= rwe_d;
            VD_OUT    <= vd_out_d;
            cpu_ack   <= ack_d;
            rd_stb    <= stb_d;
            rd_data   <= rd_data_d;
            cpu_rdata <= cpu_rdata_d;
        end
    end

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Scoreboard bench for vram_slot_arbiter: a cycle-level reference model queues
// expected bus states and strobe/ack events; a negedge monitor compares them.
module tb_vram_slot_arbiter;

    logic        clk_24M = 1'b0;
    logic        RES, line_start, render_en;
    logic [13:0] scroll_addr, mapa_addr, fix_addr, mapb_addr;
    logic        cpu_req, cpu_we;
    logic [13:0] cpu_addr;
    logic [1:0]  cpu_be;
    logic [7:0]  cpu_din;
    logic        cpu_ack;
    logic [15:0] cpu_rdata, rd_data;
    logic [3:0]  rd_stb;
    logic [12:0] RA;
    logic [1:0]  RCS, RWE;
    logic        ROE;
    logic [15:0] VD_OUT, VD_IN;
    logic [2:0]  slot;

    int vectors    = 0;
    int miscompares = 0;
    int tick       = 0;

    vram_slot_arbiter dut (
        .clk_24M(clk_24M), .RES(RES), .line_start(line_start), .render_en(render_en),
        .scroll_addr(scroll_addr), .mapa_addr(mapa_addr), .fix_addr(fix_addr), .mapb_addr(mapb_addr),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be), .cpu_din(cpu_din),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .rd_data(rd_data), .rd_stb(rd_stb),
        .RA(RA), .RCS(RCS), .ROE(ROE), .RWE(RWE), .VD_OUT(VD_OUT), .VD_IN(VD_IN), .slot(slot)
    );

    always #5 clk_24M = ~clk_24M;

    typedef struct {
        int          due;
        int          kind;
        logic [15:0] data;
    } event_t;

    typedef struct {
        int          due;
        bit          rst;
        bit          chk_ra;
        logic [12:0] ra;
        logic [1:0]  rcs;
        logic        roe;
        logic [1:0]  rwe;
        logic [15:0] vd_out;
        logic [2:0]  slot;
    } bus_t;

    event_t evq[$];
    bus_t   busq[$];

    // Model state: who owns the current slot and what it is doing.
    int          m_cyc = 0;
    int          m_kind = 0;
    logic [13:0] m_addr = '0;
    logic [1:0]  m_be = '0;
    logic [15:0] m_vdout = '0;
    logic [15:0] m_rdata = '0;
    bit          m_last_ack = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at tick %0d: got %h, expected %h", name, tick, actual, expected);
        end
    endtask

    // Reference model: slot ownership from the slot map, bus pins from the phase.
    always @(posedge clk_24M) begin
        bus_t   b;
        event_t e;
        int     ph, sl;
        bit     ack_now;
        logic [13:0] raddr [4];
        tick++;
        raddr[0] = scroll_addr; raddr[1] = mapa_addr; raddr[2] = fix_addr; raddr[3] = mapb_addr;
        if (RES) begin
            m_cyc      = 0;
            m_kind     = render_en ? 1 : 0;
            m_addr     = scroll_addr;
            m_vdout    = '0;
            m_rdata    = '0;
            m_last_ack = 1'b0;
            b = '{due: tick, rst: 1'b1, chk_ra: 1'b1, ra: 13'h0, rcs: 2'b11, roe: 1'b1,
                  rwe: 2'b11, vd_out: 16'h0, slot: 3'd0};
            busq.push_back(b);
        end else begin
            m_cyc = line_start ? 0 : (m_cyc + 1) % 32;
            ph = m_cyc % 4;
            sl = m_cyc / 4;
            if (ph == 0) begin
                if (render_en && (sl % 2 == 0)) begin
                    m_kind = 1;
                    m_addr = raddr[sl / 2];
                end else if (cpu_req && !m_last_ack) begin
                    m_kind = cpu_we ? 3 : 2;
                    m_addr = cpu_addr;
                    m_be   = cpu_be;
                    if (cpu_we) m_vdout = {cpu_din, cpu_din};
                end else begin
                    m_kind = 0;
                end
            end
            b.due    = tick;
            b.rst    = 1'b0;
            b.chk_ra = (m_kind != 0);
            b.ra     = m_addr[12:0];
            b.rcs    = 2'b11;
            if (m_kind != 0) b.rcs[m_addr[13]] = 1'b0;
            b.roe    = !((m_kind == 1 || m_kind == 2) && (ph == 1 || ph == 2));
            for (int i = 0; i < 2; i++)
                b.rwe[i] = !(m_kind == 3 && (ph == 1 || ph == 2) && m_be[i]);
            b.vd_out = m_vdout;
            b.slot   = 3'(sl);
            busq.push_back(b);
            ack_now = 1'b0;
            if (ph == 3 && m_kind == 1) begin
                e = '{due: tick, kind: sl / 2, data: VD_IN};
                evq.push_back(e);
            end else if (ph == 3 && m_kind >= 2) begin
                if (m_kind == 2) m_rdata = VD_IN;
                e = '{due: tick, kind: 4, data: m_rdata};
                evq.push_back(e);
                ack_now = 1'b1;
            end
            m_last_ack = ack_now;
        end
    end

    // Monitor: compare pins every cycle, and strobes/acks whenever the DUT shows one.
    always @(negedge clk_24M) begin
        bus_t   b;
        event_t e;
        if (busq.size() > 0) begin
            b = busq.pop_front();
            checkOutput("RCS", 32'(RCS), 32'(b.rcs));
            checkOutput("ROE", 32'(ROE), 32'(b.roe));
            checkOutput("RWE", 32'(RWE), 32'(b.rwe));
            checkOutput("VD_OUT", 32'(VD_OUT), 32'(b.vd_out));
            checkOutput("slot", 32'(slot), 32'(b.slot));
            if (b.chk_ra) checkOutput("RA", 32'(RA), 32'(b.ra));
            if (b.rst) begin
                checkOutput("reset cpu_ack", 32'(cpu_ack), 32'd0);
                checkOutput("reset rd_stb", 32'(rd_stb), 32'd0);
                checkOutput("reset rd_data", 32'(rd_data), 32'd0);
                checkOutput("reset cpu_rdata", 32'(cpu_rdata), 32'd0);
            end
        end
        if (rd_stb != 4'd0 || cpu_ack) begin
            if (evq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL spurious event at tick %0d: rd_stb=%b cpu_ack=%b, expected none", tick, rd_stb, cpu_ack);
            end else begin
                e = evq.pop_front();
                checkOutput("event tick", 32'(tick), 32'(e.due));
                if (e.kind < 4) begin
                    checkOutput("rd_stb", 32'(rd_stb), 32'(4'b0001 << e.kind));
                    checkOutput("cpu_ack", 32'(cpu_ack), 32'd0);
                    checkOutput("rd_data", 32'(rd_data), 32'(e.data));
                end else begin
                    checkOutput("cpu_ack", 32'(cpu_ack), 32'd1);
                    checkOutput("rd_stb", 32'(rd_stb), 32'd0);
                    checkOutput("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
                end
            end
        end else if (evq.size() > 0 && evq[0].due <= tick) begin
            e = evq.pop_front();
            vectors++;
            miscompares++;
            $display("[TB] FAIL missing event kind %0d at tick %0d: got rd_stb=%b cpu_ack=%b, expected a pulse",
                     e.kind, tick, rd_stb, cpu_ack);
        end
    end

    task automatic nextCycle();
        @(posedge clk_24M);
        #2;
        VD_IN = 16'($urandom);
    endtask

    // One CPU access; keep_req leaves cpu_req high after the ack.
    task automatic cpuAccess(input logic we, input logic [13:0] addr, input logic [1:0] be,
                             input logic [7:0] din, input bit keep_req);
        int n = 0;
        cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_din = din; cpu_req = 1'b1;
        do begin
            nextCycle();
            n++;
        end while (!cpu_ack && n < 400);
        if (!cpu_ack) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL ack timeout: got no cpu_ack after %0d cycles, expected one", n);
        end
        if (!keep_req) cpu_req = 1'b0;
    endtask

    // Randomised traffic with line_start, reset and render_en disturbances.
    task automatic applyStimulus(input int cycles);
        int wait_cnt = 0;
        for (int n = 0; n < cycles; n++) begin
            if (cpu_req && cpu_ack) begin
                wait_cnt = 0;
                if ($urandom_range(0, 2) == 0) begin
                    cpu_we = 1'($urandom); cpu_addr = 14'($urandom);
                    cpu_be = 2'($urandom); cpu_din = 8'($urandom);
                end else begin
                    cpu_req = 1'b0;
                end
            end else if (cpu_req) begin
                wait_cnt++;
                if (wait_cnt > 400) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL ack timeout: got no cpu_ack after %0d cycles, expected one", wait_cnt);
                    cpu_req = 1'b0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                cpu_we = 1'($urandom); cpu_addr = 14'($urandom);
                cpu_be = 2'($urandom); cpu_din = 8'($urandom);
                cpu_req = 1'b1;
                wait_cnt = 0;
            end
            line_start = ($urandom_range(0, 59) == 0);
            RES        = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 99) == 0) render_en = ~render_en;
            if ($urandom_range(0, 63) == 0) begin
                scroll_addr = 14'($urandom); mapa_addr = 14'($urandom);
                fix_addr    = 14'($urandom); mapb_addr = 14'($urandom);
            end
            nextCycle();
        end
        RES = 1'b0; line_start = 1'b0;
    endtask

    initial begin
        RES = 1'b1; line_start = 1'b0; render_en = 1'b1;
        scroll_addr = 14'h0111; mapa_addr = 14'h2222; fix_addr = 14'h1333; mapb_addr = 14'h3444;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_be = '0; cpu_din = '0; VD_IN = '0;
        repeat (3) nextCycle();
        RES = 1'b0;
        repeat (40) nextCycle();

        line_start = 1'b1; nextCycle(); line_start = 1'b0;
        repeat (5) nextCycle();
        cpuAccess(1'b1, 14'h2123, 2'b01, 8'hA5, 1'b0);
        repeat (20) nextCycle();

        render_en = 1'b0;
        line_start = 1'b1; nextCycle(); line_start = 1'b0;
        cpuAccess(1'b0, 14'h0456, 2'b11, 8'h00, 1'b0);
        repeat (10) nextCycle();

        cpuAccess(1'b0, 14'h1357, 2'b11, 8'h00, 1'b1);
        cpuAccess(1'b1, 14'h2468, 2'b10, 8'h3C, 1'b0);
        repeat (10) nextCycle();

        render_en = 1'b1;
        line_start = 1'b1; nextCycle(); line_start = 1'b0;
        repeat (11) nextCycle();
        cpu_we = 1'b1; cpu_addr = 14'h0ABC; cpu_be = 2'b11; cpu_din = 8'h5A; cpu_req = 1'b1;
        repeat (2) nextCycle();
        line_start = 1'b1; nextCycle(); line_start = 1'b0;
        cpuAccess(1'b1, 14'h0ABC, 2'b11, 8'h5A, 1'b0);
        repeat (12) nextCycle();
        cpu_we = 1'b0; cpu_addr = 14'h3001; cpu_be = 2'b11; cpu_req = 1'b1;
        repeat (2) nextCycle();
        RES = 1'b1; nextCycle(); RES = 1'b0;
        cpuAccess(1'b0, 14'h3001, 2'b11, 8'h00, 1'b0);

        applyStimulus(4000);
        cpu_req = 1'b0;
        repeat (40) nextCycle();
        if (evq.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL leftover events: got %0d pending, expected 0", evq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
